// File: rtl/serial_hex_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_hex_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/serial_hex_subtractor_if.sv
// Control/data bundle between the control logic (master) and the subtractor (slave).
//
// Handshake: the master raises Start with A/B stable; the slave accepts on a rising
// edge where Start=1 and Busy=0 (state IDLE or DONE). Start and A/B are ignored while
// Busy=1. Done pulses for exactly one cycle; D/BorrowOut/Neg/Mag are valid from that
// cycle and hold until the next accepted Start. dbg_state mirrors the FSM state.
interface serial_hex_subtractor_if
    import serial_hex_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] D;
    logic             BorrowOut;
    logic             Neg;
    logic [WIDTH-1:0] Mag;
    state_t           dbg_state;

    modport master (
        output Start, A, B,
        input  Busy, Done, D, BorrowOut, Neg, Mag, dbg_state
    );

    modport slave (
        input  Start, A, B,
        output Busy, Done, D, BorrowOut, Neg, Mag, dbg_state
    );

endinterface

// File: rtl/serial_hex_subtractor_half_subtractor.sv
// Single-bit half subtractor: In1 - In2.
module half_subtractor (
    input  logic In1,
    input  logic In2,
    output logic Diff,
    output logic Bout
);

    assign Diff = In1 ^ In2;
    assign Bout = ~In1 & In2;

endmodule

// File: rtl/serial_hex_subtractor.sv
// Bit-serial unsigned subtractor, LSB first. A first pass forms A-B; when it borrows,
// a second pass forms 0-D on the same full-subtract bit to produce the magnitude.
module serial_hex_subtractor
    import serial_hex_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  Clk,
    input  logic                  nReset,
    serial_hex_subtractor_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             busy;
    logic             done;

    // a_sr collects result bits at its MSB as operand bits leave its LSB, so after
    // a pass it holds that pass's result. b_sr rotates, so in NEG it returns to D.
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_rot;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;

    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] mag_q;
    logic             borrow_out_q;

    logic             op_a;
    logic             op_b;
    logic             hs1_diff;
    logic             hs1_bout;
    logic             hs2_bout;
    logic             diff_bit;
    logic             bout_bit;

    // Operand mux: NEG subtracts D from zero.
    assign op_a = (state == NEG) ? 1'b0 : a_sr[0];
    assign op_b = b_sr[0];

    half_subtractor u_hs_ab (
        .In1  (op_a),
        .In2  (op_b),
        .Diff (hs1_diff),
        .Bout (hs1_bout)
    );

    half_subtractor u_hs_bin (
        .In1  (hs1_diff),
        .In2  (borrow_q),
        .Diff (diff_bit),
        .Bout (hs2_bout)
    );

    assign bout_bit = hs1_bout | hs2_bout;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign a_next   = {diff_bit, a_sr[WIDTH-1:1]};
    assign b_rot    = {b_sr[0], b_sr[WIDTH-1:1]};

    // State register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    accept     = 1'b1;
                    state_next = SUB;
                end
            end
            SUB: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = bout_bit ? NEG : DONE;
                end
            end
            NEG: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (bus.Start) begin
                    accept     = 1'b1;
                    state_next = SUB;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Serial datapath; visible results change only on the edge entering DONE.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            a_sr         <= '0;
            b_sr         <= '0;
            borrow_q     <= 1'b0;
            cnt          <= '0;
            d_q          <= '0;
            mag_q        <= '0;
            borrow_out_q <= 1'b0;
        end else if (accept) begin
            a_sr     <= bus.A;
            b_sr     <= bus.B;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else if (busy) begin
            a_sr     <= a_next;
            borrow_q <= bout_bit;
            if (last_bit) begin
                cnt      <= '0;
                borrow_q <= 1'b0;
                if (state == SUB && bout_bit) begin
                    // Negative: D becomes the subtrahend of the 0 - D pass.
                    b_sr <= a_next;
                end else begin
                    b_sr         <= b_rot;
                    d_q          <= (state == NEG) ? b_rot : a_next;
                    mag_q        <= a_next;
                    borrow_out_q <= (state == NEG);
                end
            end else begin
                cnt  <= cnt + CNT_W'(1);
                b_sr <= b_rot;
            end
        end
    end

    assign bus.Busy      = busy;
    assign bus.Done      = done;
    assign bus.D         = d_q;
    assign bus.Mag       = mag_q;
    assign bus.BorrowOut = borrow_out_q;
    assign bus.Neg       = borrow_out_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_serial_hex_subtractor.sv
// Directed + randomized bench for serial_hex_subtractor against an arithmetic model.
module tb_serial_hex_subtractor;
    import serial_hex_subtractor_pkg::*;

    localparam int W = 8;

    logic Clk;
    logic nReset;
    int   n_assert;
    int   n_fail;

    serial_hex_subtractor_if #(.WIDTH(W)) bus ();

    serial_hex_subtractor #(.WIDTH(W)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    // Clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {31'd0, bus.Busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.Done}, 32'd0);
        check({tag, "_d"}, {24'd0, bus.D}, 32'd0);
        check({tag, "_mag"}, {24'd0, bus.Mag}, 32'd0);
        check({tag, "_borrow"}, {31'd0, bus.BorrowOut}, 32'd0);
        check({tag, "_neg"}, {31'd0, bus.Neg}, 32'd0);
    endtask

    // Reference results by plain arithmetic.
    task automatic model(input int a, input int b, output int d, output int neg,
                         output int mag, output int lat);
        d   = (a - b + 256) % 256;
        neg = (a < b) ? 1 : 0;
        mag = neg ? (b - a) : (a - b);
        lat = neg ? 2 * W : W;
    endtask

    task automatic check_results(input string tag, input int d, input int neg, input int mag);
        check({tag, "_d"}, {24'd0, bus.D}, d);
        check({tag, "_borrow"}, {31'd0, bus.BorrowOut}, neg);
        check({tag, "_neg"}, {31'd0, bus.Neg}, neg);
        check({tag, "_mag"}, {24'd0, bus.Mag}, mag);
    endtask

    // One operation from idle; noise=1 adds ignored Start pulses with other operands.
    task automatic run_op(input string tag, input int a, input int b, input bit noise);
        int d, neg, mag, lat, edges;
        bit seen;
        model(a, b, d, neg, mag, lat);
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.A     = a[7:0];
        bus.B     = b[7:0];
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        bus.A     = 8'($urandom);
        bus.B     = 8'($urandom);
        check({tag, "_busy_accept"}, {31'd0, bus.Busy}, 32'd1);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 4 * W) begin
            @(posedge Clk);
            #1;
            edges++;
            bus.Start = 1'b0;
            if (noise && (edges == 2 || edges == 4)) begin
                bus.Start = 1'b1;
                bus.A     = 8'($urandom);
                bus.B     = 8'($urandom);
            end
            if (bus.Done === 1'b1) seen = 1'b1;
            else check({tag, "_busy_run"}, {31'd0, bus.Busy}, 32'd1);
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, edges, lat);
        check({tag, "_busy_done"}, {31'd0, bus.Busy}, 32'd0);
        check_results(tag, d, neg, mag);
        @(posedge Clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, bus.Done}, 32'd0);
        check({tag, "_idle"}, {30'd0, bus.dbg_state}, {30'd0, IDLE});
        check_results({tag, "_hold"}, d, neg, mag);
    endtask

    initial begin
        int edges, a, b;
        bit seen;
        n_assert  = 0;
        n_fail    = 0;
        nReset    = 1'b0;
        bus.Start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        // Reset state.
        repeat (3) @(posedge Clk);
        #1;
        check_zero("reset");
        check("reset_state", {30'd0, bus.dbg_state}, {30'd0, IDLE});
        @(negedge Clk);
        nReset = 1'b1;

        // Directed vectors.
        run_op("pos", 8'h3C, 8'h1A, 1'b0);
        run_op("negv", 8'h1A, 8'h3C, 1'b0);
        run_op("zero_ff", 8'h00, 8'hFF, 1'b0);
        run_op("equal", 8'hA5, 8'hA5, 1'b0);
        run_op("noise", 8'h5A, 8'hC3, 1'b1);
        run_op("noise2", 8'hC3, 8'h5A, 1'b1);

        // Reset during the NEG pass aborts with no Done.
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.A     = 8'h1A;
        bus.B     = 8'h3C;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        repeat (11) @(posedge Clk);
        #1;
        check("abort_in_neg", {30'd0, bus.dbg_state}, {30'd0, NEG});
        nReset = 1'b0;
        #1;
        check_zero("abort");
        repeat (3) begin
            @(posedge Clk);
            #1;
            check("abort_no_done", {31'd0, bus.Done}, 32'd0);
        end
        @(negedge Clk);
        nReset = 1'b1;
        run_op("after_abort", 8'h1A, 8'h3C, 1'b0);

        // Back-to-back with Start held high.
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.A     = 8'h10;
        bus.B     = 8'h01;
        @(posedge Clk);
        #1;
        bus.A = 8'h02;
        bus.B = 8'h01;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 4 * W) begin
            @(posedge Clk);
            #1;
            edges++;
            if (bus.Done === 1'b1) seen = 1'b1;
        end
        check("b2b_first_done", {31'd0, seen}, 32'd1);
        check("b2b_first_latency", edges, W);
        check_results("b2b_first", 8'h0F, 0, 8'h0F);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 4 * W) begin
            @(posedge Clk);
            #1;
            edges++;
            if (bus.Done === 1'b1) seen = 1'b1;
        end
        check("b2b_second_done", {31'd0, seen}, 32'd1);
        check("b2b_period", edges, W + 1);
        check_results("b2b_second", 8'h01, 0, 8'h01);
        bus.Start = 1'b0;
        @(posedge Clk);
        #1;
        check("b2b_end_done", {31'd0, bus.Done}, 32'd0);

        // Random operands.
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            run_op("rand", a, b, (i % 4) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
